alu_stage_ctrl: RTL and testbench
=================================

Name: alu_stage_ctrl

Overview:
- Multicycle control FSM that sequences the execute datapath (register file, ALU B-input mux, ALU, data memory) one instruction at a time.
- Decodes the latched instruction word and drives ALU_Bin_sel and ALU_func for the ALU stage, plus load enables for the PC, IR, register file and memory.
- Waits on ready/ack handshakes from instruction and data memory, so memory latency is variable.
- Sits between the instruction register and the datapath stages in the multicycle processor top.

Parameters:
- OPW, 6, opcode field width (Instr[31:26])
- FNW, 6, func field width (Instr[5:0]); ALU_func takes func[3:0]
- MEM_TIMEOUT, 15, maximum wait cycles on any memory handshake before the Mem_err pulse

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  synchronous reset, active-low
- Instr  in  32  instruction register contents (valid from DECODE onward)
- ALU_zero  in  1  ALU Zero flag, combinational from the current operands
- IMem_ready  in  1  instruction memory data valid
- DMem_ack  in  1  data memory access complete
- IR_LdEn  out  1  load the instruction register
- PC_LdEn  out  1  load the PC
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(SignImm<<2)
- IMem_req  out  1  fetch request
- DMem_req  out  1  data access request
- DMem_WrEn  out  1  1 = store, 0 = load
- RF_WrEn  out  1  register file write
- RF_WrData_sel  out  1  0 = ALU_out, 1 = memory data
- RF_B_sel  out  1  0 = rt from Instr[15:11], 1 = rd from Instr[20:16]
- ALU_Bin_sel  out  1  0 = RF_B, 1 = Immed
- ALU_func  out  4  ALU operation
- Illegal_op  out  1  one-cycle pulse on an undefined opcode
- Mem_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset: Reset_n=0 sampled at a Clk edge forces state RESET and clears the wait counter. All outputs are 0 in RESET. Reset is honoured in any state, including mid-handshake; a pending req drops on the next cycle.
- States: RESET -> FETCH -> DECODE -> {EXEC_R, EXEC_I, ADDR, BRANCH} -> {MEM, WB} -> FETCH.
- RESET: always go to FETCH next cycle.
- FETCH: IMem_req=1 until IMem_ready. On IMem_ready, pulse IR_LdEn=1 and PC_LdEn=1 (PC_sel=0), then go to DECODE.
- DECODE: no enables asserted. Next state by opcode:
  - 100000 (R-type) -> EXEC_R
  - 111000 li, 110000 addi, 110010 andi, 110011 ori -> EXEC_I
  - 001111 lw, 011111 sw -> ADDR
  - 000000 beq, 000001 bne, 111111 b -> BRANCH
  - any other opcode -> pulse Illegal_op, return to FETCH
- EXEC_R: ALU_Bin_sel=0, ALU_func=func[3:0] -> WB.
- EXEC_I: ALU_Bin_sel=1. ALU_func: li=0000, addi=0000, andi=0010, ori=0011 -> WB.
- ADDR: ALU_Bin_sel=1, ALU_func=0000 -> MEM.
- MEM:
  - DMem_req=1 and DMem_WrEn=(opcode==sw), with ALU_Bin_sel/ALU_func held from ADDR.
  - On DMem_ack: lw -> WB with RF_WrData_sel=1; sw -> FETCH.
- WB: RF_WrEn=1 for exactly one cycle; RF_B_sel=1 for I-type/lw; ALU controls held from the previous state -> FETCH.
- BRANCH:
  - ALU_Bin_sel=0, ALU_func=0001 (sub).
  - Taken = b, or (beq & ALU_zero), or (bne & ~ALU_zero).
  - If taken: PC_LdEn=1, PC_sel=1. Not taken: no PC write, since PC+4 was already loaded in FETCH.
  - Go to FETCH.
- Timeout: a 4-bit wait counter increments each cycle a req is high without ready/ack and clears on state change. When it reaches MEM_TIMEOUT: pulse Mem_err, drop req, go to FETCH. The PC is not re-written, so a failed fetch retries the same address.
- ready/ack asserted in the same cycle req first rises is accepted, giving 0 wait cycles.
- Latency with zero-wait memory: R/I = 4 cycles, lw = 5, sw = 4, branch = 3.
- All outputs are registered-state decodes (Moore), except IR_LdEn/PC_LdEn in FETCH, DMem transitions and PC_LdEn in BRANCH, which depend on inputs (Mealy).

Decomposition:
- Shared package holds opcode localparams, ALU_func codes (ADD=0000, SUB=0001, AND=0010, OR=0011) and the state encoding; the same package is used by the ALU and the decoder.
- One sub-module, alu_ctrl_decode: combinational opcode/func -> {class, ALU_func, ALU_Bin_sel, RF_B_sel}.
- FSM and timeout counter stay in alu_stage_ctrl.

Test Plan:
- Reset_n=0 for 2 cycles in MEM mid-sw with DMem_req=1 -> next cycle all outputs 0, state RESET; after release, IMem_req=1 one cycle later.
- R-type add (opcode 100000, func 100000), zero-wait memory -> ALU_Bin_sel=0, ALU_func=0000 in EXEC_R; RF_WrEn high exactly 1 cycle, 4 cycles after FETCH entry.
- ori, IMem_ready delayed 3 cycles -> IMem_req high 4 cycles, single IR_LdEn pulse; EXEC_I shows ALU_Bin_sel=1, ALU_func=0011, RF_B_sel=1 in WB.
- lw with DMem_ack after 2 cycles -> DMem_WrEn=0, RF_WrData_sel=1 in WB; sw -> DMem_WrEn=1, no RF_WrEn, back to FETCH.
- beq with ALU_zero=1 -> PC_LdEn=1, PC_sel=1 in BRANCH; ALU_zero=0 -> PC_LdEn=0; bne gives the inverse; b is always taken.
- Opcode 101010 -> Illegal_op 1-cycle pulse, no RF/mem writes. DMem_ack never asserted -> Mem_err after 15 wait cycles, return to FETCH.

Source files
------------

// File: rtl/alu_stage_ctrl_pkg.sv
// Shared definitions for the multicycle execute-stage controller, its
// decoder and the ALU: opcodes, ALU operation codes, instruction classes
// and the controller state encoding.
package alu_stage_ctrl_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_e;

  // Controller states
  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_ADDR,
    ST_MEM,
    ST_WB,
    ST_BRANCH
  } state_e;

  // Branch resolution: unconditional b, or beq/bne qualified by the ALU zero flag
  function automatic logic branch_taken(input logic [5:0] opcode, input logic zero);
    return (opcode == OP_B) ||
           ((opcode == OP_BEQ) && zero) ||
           ((opcode == OP_BNE) && !zero);
  endfunction

endpackage

// File: rtl/alu_stage_ctrl_decode.sv
// Combinational instruction decoder: maps opcode/func to the instruction
// class and the ALU-stage controls the FSM presents while executing it.
module alu_ctrl_decode
  import alu_stage_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] func,
  output op_class_e      op_class,
  output logic [3:0]     alu_func,
  output logic           alu_bin_sel,
  output logic           rf_b_sel
);

  // Only the low four func bits select the ALU operation
  logic unused_func_hi;
  assign unused_func_hi = ^func[FNW-1:4];

  // Opcode table: class plus the ALU controls used in EXEC/ADDR/MEM/WB/BRANCH
  always_comb begin
    op_class    = CLS_ILLEGAL;
    alu_func    = ALU_ADD;
    alu_bin_sel = 1'b0;
    rf_b_sel    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        op_class = CLS_R;
        alu_func = func[3:0];
      end
      OP_LI, OP_ADDI: begin
        op_class    = CLS_I;
        alu_func    = ALU_ADD;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
      end
      OP_ANDI: begin
        op_class    = CLS_I;
        alu_func    = ALU_AND;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
      end
      OP_ORI: begin
        op_class    = CLS_I;
        alu_func    = ALU_OR;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
      end
      OP_LW, OP_SW: begin
        op_class    = CLS_MEM;
        alu_func    = ALU_ADD;
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_B: begin
        op_class = CLS_BRANCH;
        alu_func = ALU_SUB;
      end
      default: begin
        op_class = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/alu_stage_ctrl.sv
// Multicycle control FSM for the execute datapath. Sequences fetch, decode,
// execute, memory and write-back one instruction at a time, waiting on the
// instruction/data memory handshakes with a bounded wait counter.
module alu_stage_ctrl
  import alu_stage_ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int FNW         = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        IMem_ready,
  input  logic        DMem_ack,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        IMem_req,
  output logic        DMem_req,
  output logic        DMem_WrEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Illegal_op,
  output logic        Mem_err
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

  state_e          state, next_state;
  logic [3:0]      wait_cnt;
  logic            mem_timeout;
  logic            waiting;

  logic [OPW-1:0]  opcode;
  logic [FNW-1:0]  func;
  op_class_e       op_class;
  logic [3:0]      dec_alu_func;
  logic            dec_alu_bin_sel;
  logic            dec_rf_b_sel;
  logic            is_load;
  logic            is_store;
  logic            taken;

  // Register fields between opcode and func are datapath-only
  logic unused_instr_mid;
  assign unused_instr_mid = ^Instr[31-OPW:FNW];

  assign opcode   = Instr[31:32-OPW];
  assign func     = Instr[FNW-1:0];
  assign is_load  = (opcode == OP_LW);
  assign is_store = (opcode == OP_SW);
  assign taken    = branch_taken(opcode, ALU_zero);

  alu_ctrl_decode #(
    .OPW(OPW),
    .FNW(FNW)
  ) u_decode (
    .opcode      (opcode),
    .func        (func),
    .op_class    (op_class),
    .alu_func    (dec_alu_func),
    .alu_bin_sel (dec_alu_bin_sel),
    .rf_b_sel    (dec_rf_b_sel)
  );

  assign mem_timeout = (wait_cnt == TIMEOUT_CNT);
  assign waiting     = (IMem_req && !IMem_ready) || (DMem_req && !DMem_ack);

  // State register; reset is synchronous and wins over any handshake in flight
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Wait counter: counts stalled request cycles, restarts on every state change or timeout
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wait_cnt <= 4'd0;
    end else if ((next_state != state) || Mem_err) begin
      wait_cnt <= 4'd0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Next-state and output decode; handshake-dependent enables are Mealy
  always_comb begin
    next_state    = state;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    IMem_req      = 1'b0;
    DMem_req      = 1'b0;
    DMem_WrEn     = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Illegal_op    = 1'b0;
    Mem_err       = 1'b0;
    unique case (state)
      ST_RESET: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_timeout) begin
          Mem_err = 1'b1;
        end else begin
          IMem_req = 1'b1;
          if (IMem_ready) begin
            IR_LdEn    = 1'b1;
            PC_LdEn    = 1'b1;
            next_state = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        unique case (op_class)
          CLS_R:      next_state = ST_EXEC_R;
          CLS_I:      next_state = ST_EXEC_I;
          CLS_MEM:    next_state = ST_ADDR;
          CLS_BRANCH: next_state = ST_BRANCH;
          default: begin
            Illegal_op = 1'b1;
            next_state = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: begin
        ALU_Bin_sel = dec_alu_bin_sel;
        ALU_func    = dec_alu_func;
        next_state  = ST_WB;
      end
      ST_ADDR: begin
        ALU_Bin_sel = dec_alu_bin_sel;
        ALU_func    = dec_alu_func;
        next_state  = ST_MEM;
      end
      ST_MEM: begin
        ALU_Bin_sel = dec_alu_bin_sel;
        ALU_func    = dec_alu_func;
        if (mem_timeout) begin
          Mem_err    = 1'b1;
          next_state = ST_FETCH;
        end else begin
          DMem_req  = 1'b1;
          DMem_WrEn = is_store;
          if (DMem_ack) begin
            next_state = is_store ? ST_FETCH : ST_WB;
          end
        end
      end
      ST_WB: begin
        RF_WrEn       = 1'b1;
        RF_B_sel      = dec_rf_b_sel;
        RF_WrData_sel = is_load;
        ALU_Bin_sel   = dec_alu_bin_sel;
        ALU_func      = dec_alu_func;
        next_state    = ST_FETCH;
      end
      ST_BRANCH: begin
        ALU_Bin_sel = dec_alu_bin_sel;
        ALU_func    = dec_alu_func;
        if (taken) begin
          PC_LdEn = 1'b1;
          PC_sel  = 1'b1;
        end
        next_state = ST_FETCH;
      end
      default: begin
        next_state = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_stage_ctrl.sv
// Self-checking bench for alu_stage_ctrl: directed vector table, reset and
// timeout sequences, and random instructions checked against a per-instruction
// behavioural model of cycle counts, pulses and write-back controls.
module tb_alu_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic        ALU_zero = 1'b0;
  logic        IMem_ready = 1'b0;
  logic        DMem_ack = 1'b0;
  logic        IR_LdEn, PC_LdEn, PC_sel, IMem_req, DMem_req, DMem_WrEn;
  logic        RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Illegal_op, Mem_err;
  logic [3:0]  ALU_func;
  logic [15:0] all_outs;

  int n_checks = 0;
  int n_fails  = 0;

  alu_stage_ctrl #(.OPW(6), .FNW(6), .MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .ALU_zero(ALU_zero),
    .IMem_ready(IMem_ready), .DMem_ack(DMem_ack),
    .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .IMem_req(IMem_req),
    .DMem_req(DMem_req), .DMem_WrEn(DMem_WrEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .Illegal_op(Illegal_op), .Mem_err(Mem_err)
  );

  assign all_outs = {IR_LdEn, PC_LdEn, PC_sel, IMem_req, DMem_req, DMem_WrEn, RF_WrEn,
                     RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, Illegal_op, Mem_err};

  always #5 Clk = ~Clk;

  // Observed or expected per-instruction summary
  typedef struct {
    int         cycles;
    int         ir_ld;
    int         ireq;
    int         pc_wr;
    int         pc_br;
    int         rf_wr;
    int         rf_at;
    int         dreq;
    int         dwr;
    int         illegal;
    int         mem_err;
    logic [3:0] func;
    logic       bin;
    logic       bsel;
    logic       wsel;
  } summ_t;

  typedef struct {
    logic [31:0] instr;
    int          iwait;
    int          dwait;
    logic        zero;
    int          exp_cycles;
    int          exp_rf;
    int          exp_br;
    int          exp_ill;
    int          exp_err;
    logic [3:0]  exp_func;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Behavioural model: what one instruction should look like from FETCH entry
  // until the following FETCH, given memory wait counts and the zero flag.
  function automatic summ_t refModel(input logic [31:0] ins, input int iw, input int dw,
                                     input logic z);
    summ_t      e;
    logic [5:0] op;
    int         fetch_cycles;
    e  = '{default: 0};
    op = ins[31:26];
    if (iw >= 15) begin
      e.cycles  = 16;
      e.ireq    = 15;
      e.mem_err = 1;
      return e;
    end
    fetch_cycles = iw + 1;
    e.ireq  = fetch_cycles;
    e.ir_ld = 1;
    e.pc_wr = 1;
    case (op)
      6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011: begin
        e.cycles = fetch_cycles + 3;
        e.rf_wr  = 1;
        e.rf_at  = fetch_cycles + 2;
        if (op == 6'b100000) begin
          e.func = ins[3:0];
        end else begin
          e.func = (op == 6'b110010) ? 4'b0010 : (op == 6'b110011) ? 4'b0011 : 4'b0000;
          e.bin  = 1'b1;
          e.bsel = 1'b1;
        end
      end
      6'b001111, 6'b011111: begin
        if (dw >= 15) begin
          e.cycles  = fetch_cycles + 2 + 16;
          e.dreq    = 15;
          e.dwr     = (op == 6'b011111) ? 15 : 0;
          e.mem_err = 1;
        end else begin
          e.dreq = dw + 1;
          if (op == 6'b011111) begin
            e.dwr    = dw + 1;
            e.cycles = fetch_cycles + 2 + dw + 1;
          end else begin
            e.cycles = fetch_cycles + 2 + dw + 2;
            e.rf_wr  = 1;
            e.rf_at  = fetch_cycles + 2 + dw + 1;
            e.func   = 4'b0000;
            e.bin    = 1'b1;
            e.bsel   = 1'b1;
            e.wsel   = 1'b1;
          end
        end
      end
      6'b000000, 6'b000001, 6'b111111: begin
        e.cycles = fetch_cycles + 2;
        if ((op == 6'b111111) || (op == 6'b000000 && z) || (op == 6'b000001 && !z)) begin
          e.pc_br = 1;
          e.pc_wr = 2;
        end
      end
      default: begin
        e.cycles  = fetch_cycles + 1;
        e.illegal = 1;
      end
    endcase
    return e;
  endfunction

  // Plays memory for one instruction starting at the negedge of its first
  // FETCH cycle, and returns at the negedge of the next FETCH cycle.
  task automatic applyStimulus(input logic [31:0] ins, input int iw, input int dw,
                               input logic z, output summ_t m);
    int cyc;
    int ireq_seen;
    int dreq_seen;
    bit fetched;
    bit left;
    cyc = 0; ireq_seen = 0; dreq_seen = 0; fetched = 0; left = 0;
    m = '{default: 0};
    Instr    = ins;
    ALU_zero = z;
    while (1) begin
      if (left && IMem_req) break;
      if (cyc >= 64) begin
        checkOutput("cycle_budget", cyc, 0);
        break;
      end
      IMem_ready = !fetched && (ireq_seen == iw);
      DMem_ack   = (dreq_seen == dw);
      #1;
      if (IMem_req) begin ireq_seen++; m.ireq++; end
      if (IR_LdEn) begin fetched = 1; m.ir_ld++; end
      if (!IMem_req) left = 1;
      if (PC_LdEn) m.pc_wr++;
      if (PC_LdEn && PC_sel) m.pc_br++;
      if (DMem_req) begin
        dreq_seen++;
        m.dreq++;
        if (DMem_WrEn) m.dwr++;
      end
      if (RF_WrEn) begin
        m.rf_wr++;
        m.rf_at = cyc;
        m.func  = ALU_func;
        m.bin   = ALU_Bin_sel;
        m.bsel  = RF_B_sel;
        m.wsel  = RF_WrData_sel;
      end
      if (Illegal_op) m.illegal++;
      if (Mem_err) m.mem_err++;
      stepCycle();
      cyc++;
    end
    IMem_ready = 1'b0;
    DMem_ack   = 1'b0;
    m.cycles   = cyc;
  endtask

  task automatic compareAll(input string tag, input summ_t m, input summ_t e);
    checkOutput({tag, ".cycles"}, m.cycles, e.cycles);
    checkOutput({tag, ".ir_ld"}, m.ir_ld, e.ir_ld);
    checkOutput({tag, ".imem_req"}, m.ireq, e.ireq);
    checkOutput({tag, ".pc_wr"}, m.pc_wr, e.pc_wr);
    checkOutput({tag, ".pc_br"}, m.pc_br, e.pc_br);
    checkOutput({tag, ".rf_wr"}, m.rf_wr, e.rf_wr);
    checkOutput({tag, ".dmem_req"}, m.dreq, e.dreq);
    checkOutput({tag, ".dmem_wr"}, m.dwr, e.dwr);
    checkOutput({tag, ".illegal"}, m.illegal, e.illegal);
    checkOutput({tag, ".mem_err"}, m.mem_err, e.mem_err);
    if (e.rf_wr == 1 && m.rf_wr == 1) begin
      checkOutput({tag, ".wb_cycle"}, m.rf_at, e.rf_at);
      checkOutput({tag, ".wb_func"}, int'(m.func), int'(e.func));
      checkOutput({tag, ".wb_bin"}, int'(m.bin), int'(e.bin));
      checkOutput({tag, ".wb_bsel"}, int'(m.bsel), int'(e.bsel));
      checkOutput({tag, ".wb_wsel"}, int'(m.wsel), int'(e.wsel));
    end
  endtask

  // Directed vectors, then reset/handshake sequences, then random traffic
  initial begin
    vec_t        vecs[14];
    summ_t       got;
    logic [5:0]  ops[12];
    logic [31:0] ins;
    logic        z;
    int          iw, dw;

    vecs[0]  = '{{6'b100000, 20'h12345, 6'b100000}, 0, 0, 1'b0, 4, 1, 0, 0, 0, 4'b0000};
    vecs[1]  = '{{6'b110011, 20'h0abcd, 6'b000000}, 3, 0, 1'b0, 7, 1, 0, 0, 0, 4'b0011};
    vecs[2]  = '{{6'b001111, 20'h00010, 6'b000000}, 0, 2, 1'b0, 7, 1, 0, 0, 0, 4'b0000};
    vecs[3]  = '{{6'b011111, 20'h00020, 6'b000000}, 0, 0, 1'b0, 4, 0, 0, 0, 0, 4'b0000};
    vecs[4]  = '{{6'b000000, 20'h00000, 6'b000100}, 0, 0, 1'b1, 3, 0, 1, 0, 0, 4'b0000};
    vecs[5]  = '{{6'b000000, 20'h00000, 6'b000100}, 0, 0, 1'b0, 3, 0, 0, 0, 0, 4'b0000};
    vecs[6]  = '{{6'b000001, 20'h00000, 6'b000100}, 0, 0, 1'b1, 3, 0, 0, 0, 0, 4'b0000};
    vecs[7]  = '{{6'b000001, 20'h00000, 6'b000100}, 1, 0, 1'b0, 4, 0, 1, 0, 0, 4'b0000};
    vecs[8]  = '{{6'b111111, 20'h00000, 6'b000100}, 0, 0, 1'b0, 3, 0, 1, 0, 0, 4'b0000};
    vecs[9]  = '{{6'b101010, 20'h00000, 6'b000000}, 0, 0, 1'b0, 2, 0, 0, 1, 0, 4'b0000};
    vecs[10] = '{{6'b011111, 20'h00030, 6'b000000}, 0, 99, 1'b0, 19, 0, 0, 0, 1, 4'b0000};
    vecs[11] = '{{6'b100000, 20'h00000, 6'b100001}, 99, 0, 1'b0, 16, 0, 0, 0, 1, 4'b0000};
    vecs[12] = '{{6'b110010, 20'h00000, 6'b000000}, 2, 0, 1'b0, 6, 1, 0, 0, 0, 4'b0010};
    vecs[13] = '{{6'b100000, 20'h00000, 6'b110111}, 0, 0, 1'b0, 4, 1, 0, 0, 0, 4'b0111};

    ops = '{6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011, 6'b001111,
            6'b011111, 6'b000000, 6'b000001, 6'b111111, 6'b101010, 6'b010101};

    // Power-on reset
    stepCycle();
    stepCycle();
    #1;
    checkOutput("reset_outputs_zero", int'(all_outs), 0);
    Reset_n = 1'b1;
    stepCycle();
    #1;
    checkOutput("fetch_after_reset", int'(IMem_req), 1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].iwait, vecs[i].dwait, vecs[i].zero, got);
      checkOutput($sformatf("vec%0d.cycles", i), got.cycles, vecs[i].exp_cycles);
      checkOutput($sformatf("vec%0d.rf_wr", i), got.rf_wr, vecs[i].exp_rf);
      checkOutput($sformatf("vec%0d.taken", i), got.pc_br, vecs[i].exp_br);
      checkOutput($sformatf("vec%0d.illegal", i), got.illegal, vecs[i].exp_ill);
      checkOutput($sformatf("vec%0d.mem_err", i), got.mem_err, vecs[i].exp_err);
      if (vecs[i].exp_rf == 1) begin
        checkOutput($sformatf("vec%0d.func", i), int'(got.func), int'(vecs[i].exp_func));
      end
      compareAll($sformatf("vec%0d", i), got,
                 refModel(vecs[i].instr, vecs[i].iwait, vecs[i].dwait, vecs[i].zero));
    end

    // Reset asserted while a store is waiting in MEM
    Instr      = {6'b011111, 26'h0000040};
    IMem_ready = 1'b1;
    DMem_ack   = 1'b0;
    stepCycle();
    IMem_ready = 1'b0;
    stepCycle();
    stepCycle();
    #1;
    checkOutput("mid_sw.dmem_req", int'(DMem_req), 1);
    checkOutput("mid_sw.dmem_wren", int'(DMem_WrEn), 1);
    Reset_n = 1'b0;
    stepCycle();
    #1;
    checkOutput("mid_sw.reset_outputs_zero", int'(all_outs), 0);
    stepCycle();
    #1;
    checkOutput("mid_sw.reset_held_zero", int'(all_outs), 0);
    Reset_n = 1'b1;
    stepCycle();
    #1;
    checkOutput("mid_sw.fetch_after_release", int'(IMem_req), 1);

    // Random instructions against the model
    for (int i = 0; i < 40; i++) begin
      ins = {ops[$urandom_range(0, 11)], 20'($urandom), 6'($urandom)};
      iw  = $urandom_range(0, 4);
      dw  = $urandom_range(0, 4);
      z   = 1'($urandom);
      applyStimulus(ins, iw, dw, z, got);
      compareAll($sformatf("rnd%0d", i), got, refModel(ins, iw, dw, z));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
